// File: rtl/nrisc_pkg.sv
// Shared loader definitions: state encoding, programming address width and the
// default frame start byte.
package nrisc_pkg;

  localparam int         IDATA_AW    = 10;
  localparam logic [7:0] LD_SYNC_DEF = 8'hA5;

  typedef enum logic [3:0] {
    LD_IDLE,
    LD_LEN_H,
    LD_LEN_L,
    LD_DATA_H,
    LD_DATA_L,
    LD_WRITE,
    LD_CKSUM,
    LD_DONE,
    LD_ERR
  } ld_state_t;

endpackage

// File: rtl/nrisc_loader_timeout.sv
// Inter-byte watchdog: reloads to TIMEOUT on clr, counts down while en.
// Ports: clk, rst (async, active-low), clr, en -> expire (one-cycle pulse).
module nrisc_loader_timeout #(
  parameter int TIMEOUT = 1000000
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expire
);

  localparam int W = $clog2(TIMEOUT + 1);

  logic [W-1:0] cnt;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt <= W'(TIMEOUT);
    end else if (clr) begin
      cnt <= W'(TIMEOUT);
    end else if (en && cnt != '0) begin
      cnt <= cnt - W'(1);
    end
  end

  // Fires during the TIMEOUT-th idle enabled cycle so the
  // owner leaves on the following edge.
  assign expire = en && !clr && (cnt == W'(1));

endmodule

// File: rtl/nrisc_idata_loader.sv
// Serial boot loader: framed byte stream -> 16-bit IDATA programming writes.
// Ports: clk, rst (async, active-low), rx_data/rx_valid/rx_ready byte input,
// IDATA_PROG_write/addr/data memory port, core_hold, load_done, load_err,
// words_loaded. Define NRISC_LOADER_CKSUM_EN to require a trailing XOR byte.
module nrisc_idata_loader
  import nrisc_pkg::*;
#(
  parameter int         DEPTH   = 1024,
  parameter logic [7:0] SYNC    = LD_SYNC_DEF,
  parameter int         TIMEOUT = 1000000
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  output logic                rx_ready,
  output logic                IDATA_PROG_write,
  output logic [IDATA_AW-1:0] IDATA_PROG_addr,
  output logic [15:0]         IDATA_PROG_data,
  output logic                core_hold,
  output logic                load_done,
  output logic                load_err,
  output logic [10:0]         words_loaded
);

  ld_state_t   state;
  logic [7:0]  len_h;
  logic [7:0]  data_h;
  logic [10:0] len;
  logic        accept;
  logic        active;
  logic        expire;
  logic [15:0] n_rx;
  logic        last_word;
`ifdef NRISC_LOADER_CKSUM_EN
  logic [7:0]  csum;
`endif

  assign accept    = rx_valid & rx_ready;
  assign n_rx      = {len_h, rx_data};
  assign last_word = (words_loaded + 11'd1) >= len;

  always_comb begin
    active = 1'b0;
    if (state inside {LD_LEN_H, LD_LEN_L, LD_DATA_H,
                      LD_DATA_L, LD_WRITE, LD_CKSUM})
      active = 1'b1;
  end

  nrisc_loader_timeout #(
    .TIMEOUT(TIMEOUT)
  ) u_timeout (
    .clk   (clk),
    .rst   (rst),
    .clr   (accept),
    .en    (active),
    .expire(expire)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state            <= LD_IDLE;
      len_h            <= '0;
      data_h           <= '0;
      len              <= '0;
      rx_ready         <= 1'b1;
      IDATA_PROG_write <= 1'b0;
      IDATA_PROG_addr  <= '0;
      IDATA_PROG_data  <= '0;
      core_hold        <= 1'b0;
      load_done        <= 1'b0;
      load_err         <= 1'b0;
      words_loaded     <= '0;
`ifdef NRISC_LOADER_CKSUM_EN
      csum             <= '0;
`endif
    end else begin
      IDATA_PROG_write <= 1'b0;
      rx_ready         <= 1'b1;
      if (active && expire) begin
        state    <= LD_ERR;
        load_err <= 1'b1;
      end else begin
        unique case (state)
          LD_IDLE, LD_DONE, LD_ERR: begin
            // Any non-SYNC byte here is consumed and dropped.
            if (accept && rx_data == SYNC) begin
              state        <= LD_LEN_H;
              core_hold    <= 1'b1;
              load_done    <= 1'b0;
              load_err     <= 1'b0;
              words_loaded <= '0;
`ifdef NRISC_LOADER_CKSUM_EN
              csum         <= '0;
`endif
            end
          end
          LD_LEN_H: begin
            if (accept) begin
              len_h <= rx_data;
              state <= LD_LEN_L;
`ifdef NRISC_LOADER_CKSUM_EN
              csum  <= csum ^ rx_data;
`endif
            end
          end
          LD_LEN_L: begin
            if (accept) begin
`ifdef NRISC_LOADER_CKSUM_EN
              csum <= csum ^ rx_data;
`endif
              if (n_rx == '0) begin
`ifdef NRISC_LOADER_CKSUM_EN
                state     <= LD_CKSUM;
`else
                state     <= LD_DONE;
                load_done <= 1'b1;
                core_hold <= 1'b0;
`endif
              end else if (n_rx > 16'(DEPTH)) begin
                state    <= LD_ERR;
                load_err <= 1'b1;
              end else begin
                len   <= n_rx[10:0];
                state <= LD_DATA_H;
              end
            end
          end
          LD_DATA_H: begin
            if (accept) begin
              data_h <= rx_data;
              state  <= LD_DATA_L;
`ifdef NRISC_LOADER_CKSUM_EN
              csum   <= csum ^ rx_data;
`endif
            end
          end
          LD_DATA_L: begin
            // Outputs for the WRITE cycle are set up here so they
            // come straight from flops.
            if (accept) begin
              state            <= LD_WRITE;
              rx_ready         <= 1'b0;
              IDATA_PROG_write <= 1'b1;
              IDATA_PROG_addr  <= words_loaded[IDATA_AW-1:0];
              IDATA_PROG_data  <= {data_h, rx_data};
`ifdef NRISC_LOADER_CKSUM_EN
              csum             <= csum ^ rx_data;
`endif
            end
          end
          LD_WRITE: begin
            words_loaded <= words_loaded + 11'd1;
            if (!last_word) begin
              state <= LD_DATA_H;
            end else begin
`ifdef NRISC_LOADER_CKSUM_EN
              state     <= LD_CKSUM;
`else
              state     <= LD_DONE;
              load_done <= 1'b1;
              core_hold <= 1'b0;
`endif
            end
          end
`ifdef NRISC_LOADER_CKSUM_EN
          LD_CKSUM: begin
            if (accept) begin
              if (rx_data == csum) begin
                state     <= LD_DONE;
                load_done <= 1'b1;
                core_hold <= 1'b0;
              end else begin
                state    <= LD_ERR;
                load_err <= 1'b1;
              end
            end
          end
`endif
          default: state <= LD_IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_nrisc_idata_loader.sv
// Directed bench for nrisc_idata_loader (short TIMEOUT for simulation).
// Checksum bytes are sent only when NRISC_LOADER_CKSUM_EN is defined.
module tb_nrisc_idata_loader;

  localparam int TO = 40;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic [7:0]  rx_data = 8'h00;
  logic        rx_valid = 1'b0;
  logic        rx_ready;
  logic        IDATA_PROG_write;
  logic [9:0]  IDATA_PROG_addr;
  logic [15:0] IDATA_PROG_data;
  logic        core_hold;
  logic        load_done;
  logic        load_err;
  logic [10:0] words_loaded;

  int vectors = 0;
  int miscompares = 0;
  int rdy_viol = 0;
  logic [9:0]  wa[$];
  logic [15:0] wd[$];
  logic [9:0]  ea[$];
  logic [15:0] ed[$];
  logic [7:0]  tx[$];

  nrisc_idata_loader #(
    .DEPTH  (1024),
    .SYNC   (8'hA5),
    .TIMEOUT(TO)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .rx_data         (rx_data),
    .rx_valid        (rx_valid),
    .rx_ready        (rx_ready),
    .IDATA_PROG_write(IDATA_PROG_write),
    .IDATA_PROG_addr (IDATA_PROG_addr),
    .IDATA_PROG_data (IDATA_PROG_data),
    .core_hold       (core_hold),
    .load_done       (load_done),
    .load_err        (load_err),
    .words_loaded    (words_loaded)
  );

  always #5 clk = ~clk;

  // Write log plus rx_ready-low-only-in-WRITE watch.
  always @(negedge clk) begin
    if (rst) begin
      if (IDATA_PROG_write) begin
        wa.push_back(IDATA_PROG_addr);
        wd.push_back(IDATA_PROG_data);
      end
      if (rx_ready == IDATA_PROG_write) rdy_viol++;
    end
  end

  task automatic send(input logic [7:0] b);
    int n;
    n = 0;
    rx_data  = b;
    rx_valid = 1'b1;
    while (!rx_ready && n < 20) begin
      @(posedge clk); #1;
      n++;
    end
    if (!rx_ready) begin
      vectors++; miscompares++;
      $display("FAIL send_stall: rx_ready got 0 want 1");
    end
    @(posedge clk); #1;
  endtask

  // Sends tx back to back with rx_valid held high.
  task automatic send_all();
    for (int i = 0; i < tx.size(); i++) send(tx[i]);
    rx_valid = 1'b0;
  endtask

  task automatic wait_cyc(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic check_writes(input string nm);
    vectors++;
    if (wa.size() != ea.size()) begin
      miscompares++;
      $display("FAIL %s_nwr: got %0d want %0d", nm, wa.size(), ea.size());
    end
    for (int i = 0; i < ea.size() && i < wa.size(); i++) begin
      vectors++;
      if (wa[i] !== ea[i] || wd[i] !== ed[i]) begin
        miscompares++;
        $display("FAIL %s_wr%0d: got %h:%h want %h:%h",
                 nm, i, wa[i], wd[i], ea[i], ed[i]);
      end
    end
  endtask

  task automatic test_reset();
    rst = 1'b0;
    wait_cyc(3);
    rst = 1'b1;
    vectors++;
    if ({rx_ready, IDATA_PROG_write, core_hold, load_done, load_err}
        !== 5'b10000) begin
      miscompares++;
      $display("FAIL rst_flags: got %b want 10000",
               {rx_ready, IDATA_PROG_write, core_hold, load_done, load_err});
    end
    vectors++;
    if (words_loaded !== 11'd0 || IDATA_PROG_addr !== 10'd0 ||
        IDATA_PROG_data !== 16'd0) begin
      miscompares++;
      $display("FAIL rst_regs: got %h %h %h want 0 0 0",
               words_loaded, IDATA_PROG_addr, IDATA_PROG_data);
    end
  endtask

  task automatic test_good_frame();
    wa.delete(); wd.delete();
    tx = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD};
`ifdef NRISC_LOADER_CKSUM_EN
    // 00^02^12^34^AB^CD
    tx.push_back(8'h42);
`endif
    send_all();
    wait_cyc(2);
    ea = '{10'd0, 10'd1};
    ed = '{16'h1234, 16'hABCD};
    check_writes("t1");
    vectors++;
    if ({load_done, load_err, core_hold} !== 3'b100) begin
      miscompares++;
      $display("FAIL t1_status: got %b want 100",
               {load_done, load_err, core_hold});
    end
    vectors++;
    if (words_loaded !== 11'd2) begin
      miscompares++;
      $display("FAIL t1_words: got %0d want 2", words_loaded);
    end
  endtask

  task automatic test_bad_cksum();
`ifdef NRISC_LOADER_CKSUM_EN
    wa.delete(); wd.delete();
    tx = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB, 8'hCD, 8'h00};
    send_all();
    wait_cyc(2);
    check_writes("t2");
    vectors++;
    if ({load_done, load_err, core_hold} !== 3'b011) begin
      miscompares++;
      $display("FAIL t2_status: got %b want 011",
               {load_done, load_err, core_hold});
    end
`endif
  endtask

  task automatic test_len_limit();
    wa.delete(); wd.delete();
    tx = '{8'hA5, 8'h04, 8'h01};
    send_all();
    vectors++;
    if ({load_err, core_hold, load_done} !== 3'b110) begin
      miscompares++;
      $display("FAIL t3_over: got %b want 110",
               {load_err, core_hold, load_done});
    end
    wait_cyc(3);
    ea.delete(); ed.delete();
    check_writes("t3");
    // N = DEPTH is legal; the stalled frame then times out.
    tx = '{8'hA5, 8'h04, 8'h00};
    send_all();
    wait_cyc(2);
    vectors++;
    if (load_err !== 1'b0 || core_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_max: got err=%b hold=%b want err=0 hold=1",
               load_err, core_hold);
    end
    wait_cyc(TO + 5);
    vectors++;
    if (load_err !== 1'b1) begin
      miscompares++;
      $display("FAIL t3_max_to: got %b want 1", load_err);
    end
  endtask

  task automatic test_timeout();
    tx = '{8'hA5, 8'h00, 8'h01, 8'h12};
    send_all();
    wait_cyc(TO - 2);
    vectors++;
    if (load_err !== 1'b0) begin
      miscompares++;
      $display("FAIL t4_early: got %b want 0", load_err);
    end
    wait_cyc(2);
    vectors++;
    if (load_err !== 1'b1 || core_hold !== 1'b1) begin
      miscompares++;
      $display("FAIL t4_expire: got err=%b hold=%b want 1 1",
               load_err, core_hold);
    end
    test_good_frame();
  endtask

  task automatic test_back_to_back();
    wa.delete(); wd.delete();
    rdy_viol = 0;
    tx = '{8'h00, 8'hFF};
    send_all();
    wait_cyc(1);
    vectors++;
    if (load_done !== 1'b1 || core_hold !== 1'b0) begin
      miscompares++;
      $display("FAIL t5_junk: got done=%b hold=%b want 1 0",
               load_done, core_hold);
    end
    tx = '{8'hA5, 8'h00, 8'h00};
`ifdef NRISC_LOADER_CKSUM_EN
    tx.push_back(8'h00);
`endif
    send_all();
    wait_cyc(2);
    vectors++;
    if ({load_done, load_err, core_hold} !== 3'b100 ||
        words_loaded !== 11'd0 || wa.size() != 0) begin
      miscompares++;
      $display("FAIL t5_zero: got %b wl=%0d nwr=%0d want 100 0 0",
               {load_done, load_err, core_hold}, words_loaded, wa.size());
    end
    // Mid-frame SYNC bytes are plain data.
    tx = '{8'hA5, 8'h00, 8'h03, 8'hA5, 8'hA5,
           8'h00, 8'h01, 8'hFF, 8'hFF};
`ifdef NRISC_LOADER_CKSUM_EN
    tx.push_back(8'h02);
`endif
    send_all();
    wait_cyc(2);
    ea = '{10'd0, 10'd1, 10'd2};
    ed = '{16'hA5A5, 16'h0001, 16'hFFFF};
    check_writes("t5");
    vectors++;
    if (load_done !== 1'b1 || words_loaded !== 11'd3) begin
      miscompares++;
      $display("FAIL t5_done: got done=%b wl=%0d want 1 3",
               load_done, words_loaded);
    end
    vectors++;
    if (rdy_viol != 0) begin
      miscompares++;
      $display("FAIL t5_ready: got %0d bad cycles want 0", rdy_viol);
    end
  endtask

  task automatic test_mid_reset();
    tx = '{8'hA5, 8'h00, 8'h02, 8'h12, 8'h34, 8'hAB};
    send_all();
    #2;
    rst = 1'b0;
    #1;
    vectors++;
    if ({rx_ready, IDATA_PROG_write, core_hold, load_done, load_err}
        !== 5'b10000 || words_loaded !== 11'd0 ||
        IDATA_PROG_data !== 16'd0 || IDATA_PROG_addr !== 10'd0) begin
      miscompares++;
      $display("FAIL t6_async: got %b wl=%0d d=%h a=%h want 10000 0 0 0",
               {rx_ready, IDATA_PROG_write, core_hold, load_done, load_err},
               words_loaded, IDATA_PROG_data, IDATA_PROG_addr);
    end
    wait_cyc(2);
    rst = 1'b1;
    wait_cyc(1);
    test_good_frame();
  endtask

  initial begin
    test_reset();
    test_good_frame();
    test_bad_cksum();
    test_len_limit();
    test_timeout();
    test_back_to_back();
    test_mid_reset();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
